// File: rtl/reg_file_2r1w.sv
// Register file for the K2 datapath: DEPTH entries of WIDTH bits, one
// synchronous write port and two combinational read ports. Entry 0 can be
// hardwired to zero, and a same-cycle write can be forwarded to the read
// ports. A write to an address >= DEPTH raises a one-cycle error pulse.
module reg_file_2r1w #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              wr_err
);

    // One extra bit so DEPTH itself is representable when it is a power of 2.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              r_wr_err;

    logic              w_waddr_in;
    logic              w_waddr_zero;
    logic              w_wr_ok;
    logic              w_bypass_ok;
    logic [ADDR_W-1:0] w_raddr [2];
    logic [WIDTH-1:0]  w_rdata [2];

    // A write lands only when addressed inside the array and not at the
    // hardwired zero entry; bypass uses the same qualification minus clr.
    always_comb begin
        w_waddr_in   = ({1'b0, waddr} < DEPTH_C);
        w_waddr_zero = (ZERO_REG != 0) && (waddr == '0);
        w_wr_ok      = we && w_waddr_in && !w_waddr_zero;
        w_bypass_ok  = (BYPASS != 0) && w_wr_ok && !clr;
    end

    // Storage: reset and clr both wipe every entry and beat any write.
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Error pulse: high for the one cycle after an out-of-range write.
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= we && !w_waddr_in;
        end
    end

    assign w_raddr[0] = raddr_a;
    assign w_raddr[1] = raddr_b;

    // Both read ports share identical selection logic so they always agree
    // when pointed at the same address.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        // Read mux: reset, out of range and zero entry all read as zero.
        always_comb begin
            w_rdata[gi] = '0;
            if (!reset) begin
                w_rdata[gi] = '0;
            end else if ({1'b0, w_raddr[gi]} >= DEPTH_C) begin
                w_rdata[gi] = '0;
            end else if ((ZERO_REG != 0) && (w_raddr[gi] == '0)) begin
                w_rdata[gi] = '0;
            end else if (w_bypass_ok && (waddr == w_raddr[gi])) begin
                w_rdata[gi] = wdata;
            end else begin
                w_rdata[gi] = r_mem[w_raddr[gi]];
            end
        end
    end

    assign rdata_a = w_rdata[0];
    assign rdata_b = w_rdata[1];
    assign wr_err  = r_wr_err;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: a default instance, a no-bypass
// instance sharing its stimulus, and a DEPTH=5 instance for range checks.
module tb_reg_file_2r1w;

    logic       clk;
    logic       reset;
    logic       clr;
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] rda0, rdb0, rda1, rdb1;
    logic       err0, err1;

    logic       clr5;
    logic       we5;
    logic [2:0] waddr5;
    logic [7:0] wdata5;
    logic [2:0] ra5;
    logic [2:0] rb5;
    logic [7:0] rda5, rdb5;
    logic       err5;

    int total = 0;
    int bad   = 0;

    reg_file_2r1w u_dut (
        .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr_a(ra), .rdata_a(rda0), .raddr_b(rb),
        .rdata_b(rdb0), .wr_err(err0)
    );

    reg_file_2r1w #(.BYPASS(0)) u_nobyp (
        .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr_a(ra), .rdata_a(rda1), .raddr_b(rb),
        .rdata_b(rdb1), .wr_err(err1)
    );

    reg_file_2r1w #(.DEPTH(5)) u_d5 (
        .clk(clk), .reset(reset), .clr(clr5), .we(we5), .waddr(waddr5),
        .wdata(wdata5), .raddr_a(ra5), .rdata_a(rda5), .raddr_b(rb5),
        .rdata_b(rdb5), .wr_err(err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%0h", tag, got);
        end
    endtask

    // Advance to just past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        reset = 1'b0; clr = 1'b0; we = 1'b1; waddr = 2'd1; wdata = 8'hAA;
        ra = 2'd1; rb = 2'd1;
        clr5 = 1'b0; we5 = 1'b0; waddr5 = 3'd0; wdata5 = 8'h00;
        ra5 = 3'd0; rb5 = 3'd0;

        // 1: reset held with a pending write
        #1;
        check("rst_comb_a", rda0, 8'h00);
        check("rst_comb_b", rdb0, 8'h00);
        tick();
        tick();
        check("rst_hold_a", rda0, 8'h00);
        reset = 1'b1; we = 1'b0;
        #1;
        check("rst_rel_a", rda0, 8'h00);
        check("rst_rel_b", rdb0, 8'h00);
        check("rst_err", err0, 1'b0);

        // 2: basic writes and zero entry
        wr(2'd2, 8'h5C);
        wr(2'd3, 8'h3F);
        ra = 2'd2; rb = 2'd3;
        #1;
        check("rd_a2", rda0, 8'h5C);
        check("rd_b3", rdb0, 8'h3F);
        check("nb_rd_a2", rda1, 8'h5C);
        we = 1'b1; waddr = 2'd0; wdata = 8'hFF; ra = 2'd0;
        #1;
        check("zero_byp", rda0, 8'h00);
        tick();
        we = 1'b0;
        #1;
        check("zero_rd", rda0, 8'h00);

        // 3: bypass vs no bypass
        wr(2'd1, 8'h11);
        we = 1'b1; waddr = 2'd1; wdata = 8'h77; ra = 2'd1; rb = 2'd1;
        #1;
        check("byp_a", rda0, 8'h77);
        check("byp_b", rdb0, 8'h77);
        check("nobyp_a", rda1, 8'h11);
        check("nobyp_b", rdb1, 8'h11);
        tick();
        we = 1'b0;
        #1;
        check("nobyp_next", rda1, 8'h77);

        // 4: clr beats a concurrent write and suppresses bypass
        clr = 1'b1; we = 1'b1; waddr = 2'd2; wdata = 8'h99; ra = 2'd2; rb = 2'd3;
        #1;
        check("clr_nobyp", rda0, 8'h5C);
        tick();
        clr = 1'b0; we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ra = 2'(i);
            #1;
            check($sformatf("clr_rd%0d", i), rda0, 8'h00);
        end
        check("clr_err", err0, 1'b0);

        // 5: out-of-range writes on the DEPTH=5 instance
        we5 = 1'b1; waddr5 = 3'd4; wdata5 = 8'h42;
        tick();
        waddr5 = 3'd6; wdata5 = 8'hAB; ra5 = 3'd6; rb5 = 3'd4;
        #1;
        check("oor_rd6_byp", rda5, 8'h00);
        tick();
        we5 = 1'b0;
        #1;
        check("oor_err1", err5, 1'b1);
        check("oor_keep4", rdb5, 8'h42);
        check("oor_rd6", rda5, 8'h00);
        tick();
        check("oor_err_drop", err5, 1'b0);
        we5 = 1'b1; waddr5 = 3'd7;
        tick();
        check("oor_b2b_1", err5, 1'b1);
        waddr5 = 3'd5;
        tick();
        check("oor_b2b_2", err5, 1'b1);
        we5 = 1'b0;
        tick();
        check("oor_b2b_end", err5, 1'b0);

        // 6: reset mid-write
        wr(2'd1, 8'h21);
        wr(2'd3, 8'h33);
        reset = 1'b0; we = 1'b1; waddr = 2'd3; wdata = 8'h55;
        we5 = 1'b1; waddr5 = 3'd6;
        tick();
        reset = 1'b1; we = 1'b0; we5 = 1'b0; ra = 2'd3; rb = 2'd1; rb5 = 3'd4;
        #1;
        check("mid_rst_a3", rda0, 8'h00);
        check("mid_rst_b1", rdb0, 8'h00);
        check("mid_rst_err", err5, 1'b0);
        check("mid_rst_d5", rdb5, 8'h00);
        wr(2'd3, 8'h66);
        check("resume_a3", rda0, 8'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised register file for the K2 datapath: N entries of WIDTH bits, one synchronous write port and two combinational read ports.
- Next generation of the single enabled register. Adds depth, addressing, optional hardwired zero entry, write-to-read bypass, synchronous bulk clear and an out-of-range write flag.
- Sits between decode and the ALU operand muxes.

Parameters:
WIDTH, 8, data width of each entry in bits (>=1)
DEPTH, 4, number of entries (>=2; need not be a power of 2)
ADDR_W, $clog2(DEPTH), address width (derived; not overridden)
ZERO_REG, 1, if 1 entry 0 always reads 0 and writes to it are discarded
BYPASS, 1, if 1 a same-cycle write is forwarded to matching read ports

Ports:
clk  input  1  rising-edge clock
reset  input  1  reset, synchronous, active-low
clr  input  1  synchronous clear of all entries
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  WIDTH  write data
raddr_a  input  ADDR_W  read port A address
rdata_a  output  WIDTH  read port A data (combinational)
raddr_b  input  ADDR_W  read port B address
rdata_b  output  WIDTH  read port B data (combinational)
wr_err  output  1  registered pulse: previous-cycle write targeted waddr >= DEPTH

Behaviour:
Reset:
- Reset is sampled only on the rising edge of clk; there is no asynchronous path.
- At a clock edge with reset==0: all entries <= 0 and wr_err <= 0.
- While reset==0, rdata_a and rdata_b are forced to 0 combinationally.

Priority at each rising edge: reset > clr > we.
- clr==1 (reset high): all entries <= 0; any concurrent write is dropped. wr_err <= 0.
- we==1 and waddr < DEPTH: entry[waddr] <= wdata, except when ZERO_REG==1 and waddr==0 (silently discarded). wr_err <= 0.
- we==1 and waddr >= DEPTH: no entry changes; wr_err <= 1 for exactly the following cycle.
- we==0: storage holds; wr_err <= 0.

Write latency: the stored value is visible through the array one cycle after the edge. With BYPASS it is visible in the same cycle.

Read path, evaluated independently per port (p = a, b):
- reset==0 -> 0.
- raddr_p >= DEPTH -> 0.
- ZERO_REG==1 and raddr_p==0 -> 0.
- BYPASS==1 and we==1 and clr==0 and waddr==raddr_p (valid, non-zero-reg address) -> wdata.
- Otherwise -> entry[raddr_p].

Boundary rules:
- Both ports may read the same address; both return the identical value, including the bypass case.
- With BYPASS==0, a read of the address being written returns the old value in the write cycle.
- No X may propagate to rdata from unwritten entries; all entries are defined after reset.
- Reset asserted mid-write (reset==0 and we==1 on the same edge): the write is lost and the entry stays 0.
- clr with we on the same edge: the entry is 0 afterwards, and no bypass is applied during that cycle.
- wr_err is not sticky; back-to-back bad writes hold it high on consecutive cycles.

Implementation:
- Entries are an array of WIDTH-bit flops with a single always_ff on clk.
- Read muxing is always_comb.
- No latches.
- All arithmetic is address compare only; there is no width growth.

Test Plan:
1. Defaults (WIDTH=8, DEPTH=4). Hold reset=0 for 2 cycles with we=1, waddr=1, wdata=8'hAA -> after release, rdata_a/rdata_b at raddr 1 = 8'h00; wr_err=0; outputs 0 while reset low.
2. Write 8'h5C to addr 2, then 8'h3F to addr 3. Next cycle set raddr_a=2, raddr_b=3 -> rdata_a=8'h5C, rdata_b=8'h3F. Write 8'hFF to addr 0 -> reads of addr 0 return 8'h00.
3. Bypass: we=1, waddr=1, wdata=8'h77, raddr_a=raddr_b=1 in the same cycle -> rdata_a=rdata_b=8'h77 combinationally before the edge. Repeat with BYPASS=0 and old value 8'h11 -> both read 8'h11 that cycle, 8'h77 the next.
4. clr priority: entries hold 8'h5C/8'h3F. Assert clr=1 with we=1, waddr=2, wdata=8'h99 -> next cycle every address reads 8'h00 and there is no bypass during the clr cycle.
5. Out-of-range with DEPTH=5, ADDR_W=3: write 8'h42 to waddr=6 -> wr_err=1 for exactly one cycle, no entry changes, read of raddr=6 returns 0. Two consecutive bad writes -> wr_err high for 2 cycles.
6. Reset mid-operation: after entries are loaded, drive reset=0 on one edge concurrent with a write to addr 3 -> all entries 0 afterwards and wr_err=0. Normal writes resume on the first edge with reset=1.
